regfile_wr_arbiter: RTL
=======================

Name: regfile_wr_arbiter

Overview:
Shares the register file's single write port among NUM_REQ writeback requesters (ALU, load unit, multiplier, CSR path) with round-robin arbitration. It registers one granted write per cycle into a write stage that drives the register file's write enable, address and data. Writes to the hardwired zero register (X31) are acknowledged but discarded. It sits between the execute/memory writeback sources and the 32x32 register file, next to the file's 32:1 read-mux bank.

Parameters:
NUM_REQ, 4, number of writeback requesters (2..8)
DATA_W, 32, register width in bits
ADDR_W, 5, register address width; 2**ADDR_W registers
ZERO_REG, 31, register index hardwired to zero; writes to it are dropped

Ports:
clk  input  1  single clock, rising edge
reset  input  1  synchronous, active-high
req  input  NUM_REQ  per-requester write request, level
req_addr  input  NUM_REQ*ADDR_W  packed destination addresses, requester i at [i*ADDR_W +: ADDR_W]
req_data  input  NUM_REQ*DATA_W  packed write data, requester i at [i*DATA_W +: DATA_W]
gnt  output  NUM_REQ  one-hot accept strobe, combinational, same cycle as the winning req
wr_en  output  1  register-file write enable, registered
wr_addr  output  ADDR_W  register-file write address, registered
wr_data  output  DATA_W  register-file write data, registered
drop_cnt  output  16  saturating count of accepted writes dropped for targeting ZERO_REG
Interface decision: one clock; reset is synchronous and active-high (ports clk, reset).

Behaviour:
- Reset, sampled on the clk edge: wr_en=0, wr_addr=0, wr_data=0, drop_cnt=0, round-robin pointer=0. gnt is 0 while reset is high.
- Handshake:
  - A requester holds req high with stable req_addr/req_data until it sees gnt[i]=1.
  - The transfer completes in the cycle gnt[i]=1.
  - A requester may deassert req only after its grant. Dropping req before grant is legal and withdraws the request.
- Arbitration:
  - Round robin starting from the pointer.
  - Winner = first i with req[i]=1, scanning pointer, pointer+1, ... modulo NUM_REQ.
  - On a grant, the pointer becomes winner+1 modulo NUM_REQ. With no grant, the pointer holds.
  - At most one gnt bit is high per cycle. No request means gnt=0.
- Write stage:
  - A grant in cycle N gives wr_en=1 and the captured addr/data in cycle N+1. Latency is 1 cycle.
  - No grant in cycle N gives wr_en=0 in N+1; wr_addr/wr_data hold their previous values.
  - There is no back-pressure from the register file, so throughput is 1 write per cycle.
- Zero register:
  - A winner with addr==ZERO_REG is still granted and the pointer still advances.
  - wr_en=0 in N+1 and drop_cnt increments, saturating at 16'hFFFF.
- Same-address writes from two requesters in one cycle: they serialize in arbitration order, and the last grant wins in the register file.
- Starvation bound: a continuously requesting source is granted within NUM_REQ cycles.
- Reset mid-operation: pending requests are not granted that cycle. A write already in the write stage is cancelled (wr_en=0 next cycle).

Optional Feature:
REGFILE_ARB_BYPASS_EN
- When defined, add inputs rd_addr_a/rd_addr_b (ADDR_W) and rd_data_a/rd_data_b (DATA_W, raw outputs from the read-mux bank), and outputs fwd_data_a/fwd_data_b (DATA_W).
- fwd_data_x = wr_data when wr_en=1 and wr_addr==rd_addr_x and rd_addr_x!=ZERO_REG; otherwise rd_data_x. Purely combinational.
- This covers a register file that writes on the edge and reads combinationally.
- When undefined, these ports are absent and read data goes straight from the mux bank.

Decomposition:
- Package regfile_pkg holds:
  - constants REG_COUNT=32, REG_ADDR_W=5, REG_DATA_W=32, ZERO_REG_IDX=31
  - typedef reg_addr_t (logic [4:0])
  - typedef reg_data_t (logic [31:0])
  - regfile_arbiter_defaults NUM_REQ=4
- One natural sub-module: rr_arbiter (parameter N; inputs req, advance; output one-hot gnt; owns the pointer), reusable for the memory-port arbiter.
- The write-stage register, zero-register filter and drop counter stay in the top.

Test Plan:
- Reset, then req=4'b0001, addr=5, data=32'hDEADBEEF -> gnt=0001 same cycle; next cycle wr_en=1, wr_addr=5, wr_data=DEADBEEF; the cycle after, wr_en=0.
- req=4'b1111 held for 8 cycles, each requester releasing after its grant and re-requesting -> gnt order 0001, 0010, 0100, 1000, 0001...; wr_en=1 on all 8 following cycles.
- Pointer at 2, req=4'b0011 -> gnt=0001; then pointer=1, and with req=0010 still pending -> gnt=0010 next.
- req[1]=1, addr=31, data=32'h1234 -> gnt[1]=1, wr_en=0 next cycle, drop_cnt 0->1; repeat 65536 times -> drop_cnt stays at FFFF.
- Grant in cycle N with reset asserted in cycle N+1 -> wr_en=0, wr_addr=0, wr_data=0, drop_cnt=0 in N+2; gnt=0 during reset even with req=1111.
- With REGFILE_ARB_BYPASS_EN: write addr 7 = 32'hA5A5A5A5, rd_addr_a=7 and rd_data_a=0 in the wr_en cycle -> fwd_data_a=A5A5A5A5. With rd_addr_a=31 and a pending write to 31 -> fwd_data_a=rd_data_a.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared register-file constants and types for the register file and its write-port arbiter.
package regfile_pkg;

    localparam int REG_COUNT    = 32;
    localparam int REG_ADDR_W   = 5;
    localparam int REG_DATA_W   = 32;
    localparam int ZERO_REG_IDX = 31;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [REG_DATA_W-1:0] reg_data_t;

    // Default number of writeback sources sharing the write port.
    localparam int REGFILE_ARB_NUM_REQ = 4;

endpackage

// File: rtl/regfile_wr_arbiter_if.sv
// Writeback bus: requester side (req/addr/data/gnt) plus the registered register-file write port.
interface regfile_wr_arbiter_if
    import regfile_pkg::*;
#(
    parameter int NUM_REQ = REGFILE_ARB_NUM_REQ,
    parameter int DATA_W  = REG_DATA_W,
    parameter int ADDR_W  = REG_ADDR_W
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        gnt;
    logic                      wr_en;
    logic [ADDR_W-1:0]         wr_addr;
    logic [DATA_W-1:0]         wr_data;

    // Writeback sources and the register file see this side.
    modport master (
        output req, req_addr, req_data,
        input  gnt, wr_en, wr_addr, wr_data
    );

    // The arbiter.
    modport slave (
        input  req, req_addr, req_data,
        output gnt, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, scanning from a pointer that moves past each winner.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] gnt
);
    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] win;
    logic             found;

    // NOTE: every combinational output gets a default before the loop so no latch is inferred.
    always_comb begin : scan
        int j;
        j     = 0;
        gnt   = '0;
        win   = ptr;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (!found && req[PTR_W'(j)]) begin
                found = 1'b1;
                win   = PTR_W'(j);
            end
        end
        if (found) gnt[win] = 1'b1;
    end

    // NOTE: state registers use non-blocking assignments; reset is sampled on the clock edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (advance && found) begin
            ptr <= (win == PTR_W'(N - 1)) ? '0 : win + PTR_W'(1);
        end
    end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Round-robin share of the register file's single write port with a 1-cycle registered write stage.
// Optional read-after-write forwarding is enabled by defining REGFILE_ARB_BYPASS_EN.
module regfile_wr_arbiter
    import regfile_pkg::*;
#(
    parameter int NUM_REQ  = REGFILE_ARB_NUM_REQ,
    parameter int DATA_W   = REG_DATA_W,
    parameter int ADDR_W   = REG_ADDR_W,
    parameter int ZERO_REG = ZERO_REG_IDX
) (
    input  logic                clk,
    input  logic                reset,
    regfile_wr_arbiter_if.slave bus,
    output logic [15:0]         drop_cnt
`ifdef REGFILE_ARB_BYPASS_EN
    ,
    input  logic [ADDR_W-1:0]   rd_addr_a,
    input  logic [ADDR_W-1:0]   rd_addr_b,
    input  logic [DATA_W-1:0]   rd_data_a,
    input  logic [DATA_W-1:0]   rd_data_b,
    output logic [DATA_W-1:0]   fwd_data_a,
    output logic [DATA_W-1:0]   fwd_data_b
`endif
);
    logic [NUM_REQ-1:0] req_live;
    logic [NUM_REQ-1:0] gnt;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_data;
    logic               wr_en;
    logic [ADDR_W-1:0]  wr_addr;
    logic [DATA_W-1:0]  wr_data;

    // No grant may be issued while reset is held, so pending requests stay pending.
    assign req_live = reset ? '0 : bus.req;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (req_live),
        .advance (1'b1),
        .gnt     (gnt)
    );

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
                sel_data = bus.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Zero-register writes are accepted upstream but never reach the file; they are only counted.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            drop_cnt <= '0;
        end else if (|gnt) begin
            if (sel_addr == ADDR_W'(ZERO_REG)) begin
                wr_en <= 1'b0;
                if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
            end else begin
                wr_en   <= 1'b1;
                wr_addr <= sel_addr;
                wr_data <= sel_data;
            end
        end else begin
            wr_en <= 1'b0;
        end
    end

    assign bus.gnt     = gnt;
    assign bus.wr_en   = wr_en;
    assign bus.wr_addr = wr_addr;
    assign bus.wr_data = wr_data;

`ifdef REGFILE_ARB_BYPASS_EN
    // The file writes on the edge but reads combinationally, so the in-flight write is forwarded.
    assign fwd_data_a = (wr_en && wr_addr == rd_addr_a && rd_addr_a != ADDR_W'(ZERO_REG))
                        ? wr_data : rd_data_a;
    assign fwd_data_b = (wr_en && wr_addr == rd_addr_b && rd_addr_b != ADDR_W'(ZERO_REG))
                        ? wr_data : rd_data_b;
`endif

endmodule
